// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results directly and waits for load data
// (with a bounded timeout) before committing to the register file.
module writeback_stage #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_wen,
   input  logic [4:0]  in_rd,
   input  logic        in_is_load,
   input  logic [2:0]  in_funct3,
   input  logic [1:0]  in_addr_lo,
   input  logic [31:0] in_result,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rd_e,
   output logic [4:0]  rd,
   output logic [31:0] rd_v,
   output logic        pend_valid,
   output logic [4:0]  pend_rd,
   output logic        retired,
   output logic        load_err
);

   localparam int unsigned CNT_W = 8;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic [0:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   logic [4:0]       l_rd, l_rd_nxt;
   logic             l_wen, l_wen_nxt;
   logic [2:0]       l_funct3, l_funct3_nxt;
   logic [1:0]       l_addr_lo, l_addr_lo_nxt;

   logic             rd_e_nxt, retired_nxt, load_err_nxt, pend_valid_nxt;
   logic [4:0]       rd_nxt, pend_rd_nxt;
   logic [31:0]      rd_v_nxt;

   logic             bad_load;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_value;

   assign in_ready = (state == S_IDLE);
   assign cnt_inc  = cnt + CNT_W'(1);

   // Classify an incoming load as misaligned or using an unsupported funct3.
   always_comb begin
      bad_load = 1'b0;
      case (in_funct3)
         F3_LB, F3_LBU: bad_load = 1'b0;
         F3_LH, F3_LHU: bad_load = in_addr_lo[0];
         F3_LW:         bad_load = (in_addr_lo != 2'b00);
         default:       bad_load = 1'b1;
      endcase
   end

   // Pick the addressed byte/halfword from the returned word and extend it.
   always_comb begin
      ld_byte = mem_rdata[7:0];
      case (l_addr_lo)
         2'd0: ld_byte = mem_rdata[7:0];
         2'd1: ld_byte = mem_rdata[15:8];
         2'd2: ld_byte = mem_rdata[23:16];
         2'd3: ld_byte = mem_rdata[31:24];
         default: ld_byte = mem_rdata[7:0];
      endcase
      ld_half = l_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (l_funct3)
         F3_LB:   ld_value = {{24{ld_byte[7]}}, ld_byte};
         F3_LH:   ld_value = {{16{ld_half[15]}}, ld_half};
         F3_LBU:  ld_value = {24'd0, ld_byte};
         F3_LHU:  ld_value = {16'd0, ld_half};
         default: ld_value = mem_rdata;
      endcase
   end

   // Next-state and next-output logic; pulses default low, data holds.
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      l_rd_nxt       = l_rd;
      l_wen_nxt      = l_wen;
      l_funct3_nxt   = l_funct3;
      l_addr_lo_nxt  = l_addr_lo;
      rd_e_nxt       = 1'b0;
      rd_nxt         = rd;
      rd_v_nxt       = rd_v;
      pend_valid_nxt = pend_valid;
      pend_rd_nxt    = pend_rd;
      retired_nxt    = 1'b0;
      load_err_nxt   = 1'b0;

      case (state)
         S_IDLE: begin
            if (in_valid) begin
               if (!in_is_load) begin
                  retired_nxt = 1'b1;
                  if (in_wen && (in_rd != 5'd0)) begin
                     rd_e_nxt = 1'b1;
                     rd_nxt   = in_rd;
                     rd_v_nxt = in_result;
                  end
               end else if (bad_load) begin
                  retired_nxt  = 1'b1;
                  load_err_nxt = 1'b1;
               end else begin
                  state_nxt      = S_WAIT;
                  cnt_nxt        = '0;
                  l_rd_nxt       = in_rd;
                  l_wen_nxt      = in_wen;
                  l_funct3_nxt   = in_funct3;
                  l_addr_lo_nxt  = in_addr_lo;
                  pend_valid_nxt = in_wen && (in_rd != 5'd0);
                  pend_rd_nxt    = in_rd;
               end
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               state_nxt      = S_IDLE;
               retired_nxt    = 1'b1;
               pend_valid_nxt = 1'b0;
               pend_rd_nxt    = 5'd0;
               if (l_wen && (l_rd != 5'd0)) begin
                  rd_e_nxt = 1'b1;
                  rd_nxt   = l_rd;
                  rd_v_nxt = ld_value;
               end
            end else begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                  state_nxt      = S_IDLE;
                  retired_nxt    = 1'b1;
                  load_err_nxt   = 1'b1;
                  pend_valid_nxt = 1'b0;
                  pend_rd_nxt    = 5'd0;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, latched load context and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         l_rd       <= 5'd0;
         l_wen      <= 1'b0;
         l_funct3   <= 3'd0;
         l_addr_lo  <= 2'd0;
         rd_e       <= 1'b0;
         rd         <= 5'd0;
         rd_v       <= 32'd0;
         pend_valid <= 1'b0;
         pend_rd    <= 5'd0;
         retired    <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         l_rd       <= l_rd_nxt;
         l_wen      <= l_wen_nxt;
         l_funct3   <= l_funct3_nxt;
         l_addr_lo  <= l_addr_lo_nxt;
         rd_e       <= rd_e_nxt;
         rd         <= rd_nxt;
         rd_v       <= rd_v_nxt;
         pend_valid <= pend_valid_nxt;
         pend_rd    <= pend_rd_nxt;
         retired    <= retired_nxt;
         load_err   <= load_err_nxt;
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized traffic
// checked against a register-file-level model of retirement.
module tb_writeback_stage;

   localparam int unsigned T = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_wen, in_is_load;
   logic [4:0]  in_rd;
   logic [2:0]  in_funct3;
   logic [1:0]  in_addr_lo;
   logic [31:0] in_result;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rd_e, pend_valid, retired, load_err;
   logic [4:0]  rd, pend_rd;
   logic [31:0] rd_v;

   int checks = 0;
   int errors = 0;

   // Model of the register-file write port: last written index/value.
   logic [4:0]  exp_rd  = 5'd0;
   logic [31:0] exp_rdv = 32'd0;

   writeback_stage #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen),
      .in_rd(in_rd), .in_is_load(in_is_load), .in_funct3(in_funct3),
      .in_addr_lo(in_addr_lo), .in_result(in_result),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rd_e(rd_e), .rd(rd), .rd_v(rd_v),
      .pend_valid(pend_valid), .pend_rd(pend_rd),
      .retired(retired), .load_err(load_err)
   );

   always #5 clk = ~clk;

   // Expected load result from plain arithmetic on the returned word.
   function automatic logic [31:0] model_ext(input int f3, input int addr, input logic [31:0] data);
      logic [31:0] b, h;
      b = (data >> (8 * addr)) & 32'h0000_00FF;
      h = (data >> (16 * (addr / 2))) & 32'h0000_FFFF;
      case (f3)
         0: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
         1: return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
         4: return b;
         5: return h;
         default: return data;
      endcase
   endfunction

   function automatic bit model_illegal(input int f3, input int addr);
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
      if ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) return 1'b1;
      if (f3 == 2 && addr != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic wen, input logic [4:0] r,
                        input logic [2:0] f3, input logic [1:0] a, input logic [31:0] res);
      in_valid = 1'b1; in_is_load = ld; in_wen = wen; in_rd = r;
      in_funct3 = f3; in_addr_lo = a; in_result = res;
      step();
      in_valid = 1'b0;
   endtask

   task automatic pulse_rvalid(input logic [31:0] data);
      mem_rvalid = 1'b1; mem_rdata = data;
      step();
      mem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({rd_e, retired, load_err, pend_valid} !== 4'b0000 || rd !== 5'd0 ||
          rd_v !== 32'd0 || pend_rd !== 5'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_outputs got e=%b ret=%b err=%b pv=%b rd=%0d rdv=%h prd=%0d rdy=%b exp all zero, rdy=1",
                  rd_e, retired, load_err, pend_valid, rd, rd_v, pend_rd, in_ready);
      end
   endtask

   task automatic test_nonload();
      issue(1'b0, 1'b1, 5'd5, 3'd0, 2'd0, 32'hDEAD_BEEF);
      exp_rd = 5'd5; exp_rdv = 32'hDEAD_BEEF;
      checks++;
      if ({rd_e, retired, load_err, in_ready} !== 4'b1101 || rd !== exp_rd || rd_v !== exp_rdv) begin
         errors++;
         $display("FAIL nonload_basic got e=%b ret=%b err=%b rdy=%b rd=%0d rdv=%h exp 1 1 0 1 rd=5 rdv=deadbeef",
                  rd_e, retired, load_err, in_ready, rd, rd_v);
      end
      step();
      checks++;
      if ({rd_e, retired} !== 2'b00 || rd !== exp_rd || rd_v !== exp_rdv) begin
         errors++;
         $display("FAIL nonload_pulse got e=%b ret=%b rd=%0d rdv=%h exp 0 0 held", rd_e, retired, rd, rd_v);
      end
      // Destination x0: retires without a write, port holds previous value.
      issue(1'b0, 1'b1, 5'd0, 3'd0, 2'd0, 32'h1234_5678);
      checks++;
      if ({rd_e, retired} !== 2'b01 || rd !== exp_rd || rd_v !== exp_rdv) begin
         errors++;
         $display("FAIL nonload_rd0 got e=%b ret=%b rd=%0d rdv=%h exp e=0 ret=1 rd=%0d rdv=%h",
                  rd_e, retired, rd, rd_v, exp_rd, exp_rdv);
      end
   endtask

   task automatic test_load_directed();
      // LB from byte 3 of 0x80FF0000, data after two idle wait cycles.
      issue(1'b1, 1'b1, 5'd7, 3'b000, 2'd3, 32'd0);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (pend_valid !== 1'b1 || pend_rd !== 5'd7 || in_ready !== 1'b0 || retired !== 1'b0) begin
            errors++;
            $display("FAIL lb_pending got pv=%b prd=%0d rdy=%b ret=%b exp 1 7 0 0", pend_valid, pend_rd, in_ready, retired);
         end
         step();
      end
      pulse_rvalid(32'h80FF_0000);
      exp_rd = 5'd7; exp_rdv = 32'hFFFF_FF80;
      checks++;
      if ({rd_e, retired, load_err, in_ready, pend_valid} !== 5'b11010 || rd !== exp_rd || rd_v !== exp_rdv) begin
         errors++;
         $display("FAIL lb_commit got e=%b ret=%b err=%b rdy=%b pv=%b rd=%0d rdv=%h exp rd=7 rdv=ffffff80",
                  rd_e, retired, load_err, in_ready, pend_valid, rd, rd_v);
      end
      // LHU upper half.
      issue(1'b1, 1'b1, 5'd9, 3'b101, 2'd2, 32'd0);
      pulse_rvalid(32'h8001_1234);
      exp_rd = 5'd9; exp_rdv = 32'h0000_8001;
      checks++;
      if (rd_e !== 1'b1 || rd !== exp_rd || rd_v !== exp_rdv) begin
         errors++;
         $display("FAIL lhu_commit got e=%b rd=%0d rdv=%h exp 1 9 00008001", rd_e, rd, rd_v);
      end
      // LW aligned.
      issue(1'b1, 1'b1, 5'd10, 3'b010, 2'd0, 32'd0);
      pulse_rvalid(32'hCAFE_F00D);
      exp_rd = 5'd10; exp_rdv = 32'hCAFE_F00D;
      checks++;
      if (rd_e !== 1'b1 || rd !== exp_rd || rd_v !== exp_rdv) begin
         errors++;
         $display("FAIL lw_commit got e=%b rd=%0d rdv=%h exp 1 10 cafef00d", rd_e, rd, rd_v);
      end
   endtask

   task automatic test_misaligned();
      logic [2:0] f3s [3];
      logic [1:0] as  [3];
      f3s[0] = 3'b010; as[0] = 2'd2;
      f3s[1] = 3'b001; as[1] = 2'd1;
      f3s[2] = 3'b011; as[2] = 2'd0;
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 1'b1, 5'd12, f3s[i], as[i], 32'd0);
         checks++;
         if ({load_err, retired, rd_e, in_ready, pend_valid} !== 5'b11010 || rd !== exp_rd || rd_v !== exp_rdv) begin
            errors++;
            $display("FAIL bad_load%0d got err=%b ret=%b e=%b rdy=%b pv=%b exp 1 1 0 1 0", i,
                     load_err, retired, rd_e, in_ready, pend_valid);
         end
      end
      step();
      checks++;
      if ({load_err, retired} !== 2'b00) begin
         errors++;
         $display("FAIL bad_load_pulse got err=%b ret=%b exp 0 0", load_err, retired);
      end
   endtask

   task automatic test_timeout();
      issue(1'b1, 1'b1, 5'd3, 3'b000, 2'd1, 32'd0);
      for (int i = 1; i <= int'(T); i++) begin
         step();
         if (i < int'(T)) begin
            checks++;
            if ({load_err, retired, in_ready} !== 3'b000) begin
               errors++;
               $display("FAIL timeout_wait%0d got err=%b ret=%b rdy=%b exp 0 0 0", i, load_err, retired, in_ready);
            end
         end
      end
      checks++;
      if ({load_err, retired, rd_e, in_ready, pend_valid} !== 5'b11010) begin
         errors++;
         $display("FAIL timeout_fire got err=%b ret=%b e=%b rdy=%b pv=%b exp 1 1 0 1 0",
                  load_err, retired, rd_e, in_ready, pend_valid);
      end
      step();
      checks++;
      if ({load_err, retired} !== 2'b00) begin
         errors++;
         $display("FAIL timeout_pulse got err=%b ret=%b exp 0 0", load_err, retired);
      end
   endtask

   task automatic test_back_to_back();
      logic       wen;
      logic [4:0] r;
      logic [31:0] res;
      for (int i = 0; i < 8; i++) begin
         wen = 1'($urandom); r = 5'($urandom); res = $urandom;
         in_valid = 1'b1; in_is_load = 1'b0; in_wen = wen; in_rd = r; in_result = res;
         step();
         if (wen && r != 5'd0) begin exp_rd = r; exp_rdv = res; end
         checks++;
         if (rd_e !== (wen && r != 5'd0) || retired !== 1'b1 || rd !== exp_rd || rd_v !== exp_rdv) begin
            errors++;
            $display("FAIL b2b%0d got e=%b ret=%b rd=%0d rdv=%h exp e=%b ret=1 rd=%0d rdv=%h",
                     i, rd_e, retired, rd, rd_v, (wen && r != 5'd0), exp_rd, exp_rdv);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      int late_bad;
      issue(1'b1, 1'b1, 5'd9, 3'b010, 2'd0, 32'd0);
      step();
      #2 rst_n = 1'b0;
      #1;
      exp_rd = 5'd0; exp_rdv = 32'd0;
      checks++;
      if ({rd_e, retired, load_err, pend_valid} !== 4'b0000 || in_ready !== 1'b1 || rd !== 5'd0 || rd_v !== 32'd0) begin
         errors++;
         $display("FAIL reset_in_wait got e=%b ret=%b err=%b pv=%b rdy=%b rd=%0d rdv=%h exp zeros rdy=1",
                  rd_e, retired, load_err, pend_valid, in_ready, rd, rd_v);
      end
      step();
      rst_n = 1'b1;
      step();
      pulse_rvalid(32'h5555_AAAA);
      checks++;
      if ({rd_e, retired, load_err} !== 3'b000 || rd_v !== exp_rdv) begin
         errors++;
         $display("FAIL late_rvalid got e=%b ret=%b err=%b rdv=%h exp 0 0 0 0", rd_e, retired, load_err, rd_v);
      end
      late_bad = 0;
      for (int i = 0; i < int'(T) + 4; i++) begin
         step();
         if ({rd_e, retired, load_err} !== 3'b000) late_bad++;
      end
      checks++;
      if (late_bad != 0) begin
         errors++;
         $display("FAIL abandoned_load got %0d active cycles exp 0", late_bad);
      end
   endtask

   task automatic test_random();
      logic        ld, wen, we, timed;
      logic [4:0]  r;
      logic [2:0]  f3;
      logic [1:0]  a;
      logic [31:0] res, data, val;
      int          d;
      for (int n = 0; n < 80; n++) begin
         // Stray response while idle must be ignored.
         if ($urandom_range(0, 5) == 0) begin
            pulse_rvalid($urandom);
            checks++;
            if ({rd_e, retired, load_err} !== 3'b000 || in_ready !== 1'b1) begin
               errors++;
               $display("FAIL idle_rvalid%0d got e=%b ret=%b err=%b rdy=%b exp 0 0 0 1", n, rd_e, retired, load_err, in_ready);
            end
         end
         ld = 1'($urandom); wen = 1'($urandom_range(0, 3) != 0); r = 5'($urandom);
         f3 = 3'($urandom); a = 2'($urandom); res = $urandom;
         we = wen && (r != 5'd0);
         issue(ld, wen, r, f3, a, res);
         if (!ld) begin
            if (we) begin exp_rd = r; exp_rdv = res; end
            checks++;
            if (rd_e !== we || {retired, load_err, in_ready} !== 3'b101 || rd !== exp_rd || rd_v !== exp_rdv) begin
               errors++;
               $display("FAIL rnd_alu%0d got e=%b ret=%b err=%b rd=%0d rdv=%h exp e=%b rd=%0d rdv=%h",
                        n, rd_e, retired, load_err, rd, rd_v, we, exp_rd, exp_rdv);
            end
         end else if (model_illegal(int'(f3), int'(a))) begin
            checks++;
            if ({load_err, retired, rd_e, in_ready} !== 4'b1101 || rd !== exp_rd || rd_v !== exp_rdv) begin
               errors++;
               $display("FAIL rnd_bad%0d f3=%0d a=%0d got err=%b ret=%b e=%b rdy=%b exp 1 1 0 1",
                        n, f3, a, load_err, retired, rd_e, in_ready);
            end
         end else begin
            checks++;
            if (in_ready !== 1'b0 || pend_valid !== we || (we && pend_rd !== r) || retired !== 1'b0) begin
               errors++;
               $display("FAIL rnd_pend%0d got rdy=%b pv=%b prd=%0d ret=%b exp 0 %b %0d 0", n, in_ready, pend_valid, pend_rd, retired, we, r);
            end
            d = $urandom_range(0, int'(T) + 3);
            timed = 1'b0;
            for (int i = 1; i <= d; i++) begin
               step();
               if (i == int'(T)) begin timed = 1'b1; break; end
               checks++;
               if ({in_ready, retired, rd_e, load_err} !== 4'b0000) begin
                  errors++;
                  $display("FAIL rnd_wait%0d.%0d got rdy=%b ret=%b e=%b err=%b exp 0", n, i, in_ready, retired, rd_e, load_err);
               end
            end
            if (timed) begin
               checks++;
               if ({load_err, retired, rd_e, in_ready, pend_valid} !== 5'b11010 || rd_v !== exp_rdv) begin
                  errors++;
                  $display("FAIL rnd_timeout%0d got err=%b ret=%b e=%b rdy=%b pv=%b exp 1 1 0 1 0",
                           n, load_err, retired, rd_e, in_ready, pend_valid);
               end
            end else begin
               data = $urandom;
               pulse_rvalid(data);
               val = model_ext(int'(f3), int'(a), data);
               if (we) begin exp_rd = r; exp_rdv = val; end
               checks++;
               if (rd_e !== we || {retired, load_err, in_ready, pend_valid} !== 4'b1010 ||
                   rd !== exp_rd || rd_v !== exp_rdv) begin
                  errors++;
                  $display("FAIL rnd_load%0d f3=%0d a=%0d d=%0d data=%h got e=%b ret=%b err=%b rd=%0d rdv=%h exp e=%b rd=%0d rdv=%h",
                           n, f3, a, d, data, rd_e, retired, load_err, rd, rd_v, we, exp_rd, exp_rdv);
               end
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_wen = 1'b0; in_rd = 5'd0; in_is_load = 1'b0;
      in_funct3 = 3'd0; in_addr_lo = 2'd0; in_result = 32'd0;
      mem_rvalid = 1'b0; mem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      step();
      test_nonload();
      test_load_directed();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_reset_in_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
